uart_tx_scheduler: RTL and testbench

//  Shares the single UART transmitter between NUM_CH traveler/machine data sources. Each source

---
 rtl/uart_tx_scheduler.sv | 170 +++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART TX among NUM_CH toggle-flag byte sources.
// Define UART_CH_TAG_EN to precede every data byte with a {4'hF, ch} tag byte.
module uart_tx_scheduler #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned DROP_W = 8
) (
    input  logic                uart_clk,
    input  logic                rst,
    input  logic [NUM_CH*9-1:0] ch_data,
    input  logic                tx_ready,
    output logic                tx_valid,
    output logic [7:0]          tx_data,
    output logic [3:0]          tx_ch,
    output logic                sched_busy,
    output logic [DROP_W-1:0]   drop_cnt,
    output logic [7:0]          leds
);

    localparam int unsigned SUM_W = DROP_W + 5;

    typedef enum logic [1:0] {IDLE, TAG, DATA} state_t;

    state_t            state;
    logic              prime;
    logic [NUM_CH-1:0] flag;
    logic [NUM_CH-1:0] last_flag;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] evt;
    logic [NUM_CH-1:0] take;
    logic [7:0]        data_in   [NUM_CH];
    logic [7:0]        pend_data [NUM_CH];
    logic [3:0]        rr;
    logic [3:0]        grant;
    logic [3:0]        hi_idx;
    logic [3:0]        lo_idx;
    logic [7:0]        grant_data;
    logic [7:0]        hi_data;
    logic [7:0]        lo_data;
    logic              hi_vld;
    logic              lo_vld;
    logic              grant_vld;
    logic [4:0]        n_drop;
    logic [SUM_W-1:0]  drop_sum;
    logic [DROP_W-1:0] drop_next;
`ifdef UART_CH_TAG_EN
    logic [7:0]        hold;
`endif

    // Unpack channels and detect flag toggles (suppressed during the prime cycle)
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            flag[i]    = ch_data[9*i];
            data_in[i] = ch_data[9*i+1 +: 8];
            evt[i]     = !prime && (flag[i] != last_flag[i]);
        end
    end

    // Round-robin: lowest pending above rr wins, else lowest pending at or below rr
    always_comb begin
        hi_vld  = 1'b0;
        lo_vld  = 1'b0;
        hi_idx  = '0;
        lo_idx  = '0;
        hi_data = '0;
        lo_data = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending[i]) begin
                if (4'(i) > rr) begin
                    hi_vld  = 1'b1;
                    hi_idx  = 4'(i);
                    hi_data = pend_data[i];
                end else begin
                    lo_vld  = 1'b1;
                    lo_idx  = 4'(i);
                    lo_data = pend_data[i];
                end
            end
        end
        grant_vld  = hi_vld || lo_vld;
        grant      = hi_vld ? hi_idx : lo_idx;
        grant_data = hi_vld ? hi_data : lo_data;
    end

    // A same-edge event on the granted channel re-arms it and is not a drop
    always_comb begin
        n_drop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            take[i] = (state == IDLE) && grant_vld && (grant == 4'(i));
            n_drop  = n_drop + 5'(evt[i] && pending[i] && !take[i]);
        end
        drop_sum  = SUM_W'(drop_cnt) + SUM_W'(n_drop);
        drop_next = (drop_sum > SUM_W'({DROP_W{1'b1}})) ? {DROP_W{1'b1}} : DROP_W'(drop_sum);
    end

    always_ff @(posedge uart_clk) begin
        if (rst) begin
            state      <= IDLE;
            prime      <= 1'b1;
            last_flag  <= '0;
            pending    <= '0;
            rr         <= 4'(NUM_CH - 1);
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            tx_ch      <= '0;
            sched_busy <= 1'b0;
            drop_cnt   <= '0;
            leds       <= '0;
            for (int i = 0; i < NUM_CH; i++) pend_data[i] <= '0;
`ifdef UART_CH_TAG_EN
            hold       <= '0;
`endif
        end else begin
            if (prime) begin
                last_flag <= flag;
                prime     <= 1'b0;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (evt[i]) begin
                    last_flag[i] <= flag[i];
                    pend_data[i] <= data_in[i];
                    pending[i]   <= 1'b1;
                end else if (take[i]) begin
                    pending[i]   <= 1'b0;
                end
            end
            drop_cnt <= drop_next;

            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        tx_valid   <= 1'b1;
                        tx_ch      <= grant;
                        rr         <= grant;
                        sched_busy <= 1'b1;
`ifdef UART_CH_TAG_EN
                        tx_data    <= {4'hF, grant};
                        hold       <= grant_data;
                        state      <= TAG;
`else
                        tx_data    <= grant_data;
                        state      <= DATA;
`endif
                    end
                end
`ifdef UART_CH_TAG_EN
                TAG: begin
                    if (tx_ready) begin
                        tx_data <= hold;
                        state   <= DATA;
                    end
                end
`endif
                DATA: begin
                    if (tx_ready) begin
                        tx_valid   <= 1'b0;
                        leds       <= tx_data;
                        sched_busy <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    tx_valid   <= 1'b0;
                    sched_busy <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler (two channels): table-driven rows plus hand sequences.
module tb_uart_tx_scheduler;

    localparam int unsigned NUM_CH = 2;
    localparam int unsigned DROP_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              f0, f1;
    logic [7:0]        d0, d1;
    logic              tx_ready;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic [3:0]        tx_ch;
    logic              sched_busy;
    logic [DROP_W-1:0] drop_cnt;
    logic [7:0]        leds;
    logic [NUM_CH*9-1:0] ch_data;
    logic [29:0]       obs;

    int checks = 0;
    int errors = 0;

    assign ch_data = {d1, f1, d0, f0};
    assign obs     = {tx_valid, tx_data, tx_ch, sched_busy, leds, drop_cnt};

    always #5 clk = ~clk;

    uart_tx_scheduler #(.NUM_CH(NUM_CH), .DROP_W(DROP_W)) dut (
        .uart_clk  (clk),
        .rst       (rst),
        .ch_data   (ch_data),
        .tx_ready  (tx_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ch     (tx_ch),
        .sched_busy(sched_busy),
        .drop_cnt  (drop_cnt),
        .leds      (leds)
    );

    typedef struct {
        logic        rst;
        logic        f0;
        logic [7:0]  d0;
        logic        f1;
        logic [7:0]  d1;
        logic        rdy;
        logic [29:0] exp;
    } vec_t;

    vec_t tbl [16];

    function automatic logic [29:0] o(logic v, logic [7:0] d, logic [3:0] c, logic b,
                                      logic [7:0] l, logic [7:0] dr);
        return {v, d, c, b, l, dr};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; f0 = 1'b1; f1 = 1'b0; d0 = 8'h00; d1 = 8'h00; tx_ready = 1'b1;

        // reset with ch0 flag held high, then no spurious event after release
        step(); step();
        check("reset_state", 32'(obs), 32'(o(0, 8'h00, 4'h0, 0, 8'h00, 8'h00)));
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("prime_no_valid", 32'(tx_valid), 32'd0);
        end
        check("prime_no_drop", 32'(drop_cnt), 32'd0);

`ifndef UART_CH_TAG_EN
        // {rst, f0, d0, f1, d1, rdy, expected after edge}
        tbl[0]  = '{0, 0, 8'h5A, 0, 8'h00, 1, o(0, 8'h00, 4'h0, 0, 8'h00, 8'h00)};
        tbl[1]  = '{0, 0, 8'h5A, 0, 8'h00, 1, o(1, 8'h5A, 4'h0, 1, 8'h00, 8'h00)};
        tbl[2]  = '{0, 0, 8'h5A, 0, 8'h00, 1, o(0, 8'h5A, 4'h0, 0, 8'h5A, 8'h00)};
        tbl[3]  = '{0, 0, 8'h5A, 0, 8'h00, 1, o(0, 8'h5A, 4'h0, 0, 8'h5A, 8'h00)};
        tbl[4]  = '{1, 0, 8'h5A, 0, 8'h00, 1, o(0, 8'h00, 4'h0, 0, 8'h00, 8'h00)};
        tbl[5]  = '{0, 0, 8'h5A, 0, 8'h00, 1, o(0, 8'h00, 4'h0, 0, 8'h00, 8'h00)};
        tbl[6]  = '{0, 1, 8'h11, 1, 8'h22, 1, o(0, 8'h00, 4'h0, 0, 8'h00, 8'h00)};
        tbl[7]  = '{0, 1, 8'h11, 1, 8'h22, 1, o(1, 8'h11, 4'h0, 1, 8'h00, 8'h00)};
        tbl[8]  = '{0, 1, 8'h11, 1, 8'h22, 1, o(0, 8'h11, 4'h0, 0, 8'h11, 8'h00)};
        tbl[9]  = '{0, 1, 8'h11, 1, 8'h22, 1, o(1, 8'h22, 4'h1, 1, 8'h11, 8'h00)};
        tbl[10] = '{0, 1, 8'h11, 1, 8'h22, 1, o(0, 8'h22, 4'h1, 0, 8'h22, 8'h00)};
        tbl[11] = '{0, 0, 8'h11, 0, 8'h22, 1, o(0, 8'h22, 4'h1, 0, 8'h22, 8'h00)};
        tbl[12] = '{0, 0, 8'h11, 0, 8'h22, 1, o(1, 8'h11, 4'h0, 1, 8'h22, 8'h00)};
        tbl[13] = '{0, 0, 8'h11, 0, 8'h22, 1, o(0, 8'h11, 4'h0, 0, 8'h11, 8'h00)};
        tbl[14] = '{0, 0, 8'h11, 0, 8'h22, 1, o(1, 8'h22, 4'h1, 1, 8'h11, 8'h00)};
        tbl[15] = '{0, 0, 8'h11, 0, 8'h22, 1, o(0, 8'h22, 4'h1, 0, 8'h22, 8'h00)};
        for (int i = 0; i < 16; i++) begin
            rst = tbl[i].rst; f0 = tbl[i].f0; d0 = tbl[i].d0;
            f1 = tbl[i].f1; d1 = tbl[i].d1; tx_ready = tbl[i].rdy;
            step();
            check($sformatf("row%0d", i), 32'(obs), 32'(tbl[i].exp));
        end

        // stall in DATA while ch1 is overwritten once
        f0 = 1'b1; d0 = 8'hAA; tx_ready = 1'b0;
        step();
        check("stall_pend", 32'(tx_valid), 32'd0);
        step();
        check("stall_grant", 32'({tx_valid, tx_data, tx_ch}), 32'({1'b1, 8'hAA, 4'h0}));
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin f1 = 1'b1; d1 = 8'h33; end
            if (i == 5) begin f1 = 1'b0; d1 = 8'h44; end
            step();
            check("stall_hold", 32'({tx_valid, tx_data, tx_ch}), 32'({1'b1, 8'hAA, 4'h0}));
        end
        check("stall_drop", 32'(drop_cnt), 32'd1);
        tx_ready = 1'b1;
        step();
        check("stall_accept", 32'({tx_valid, leds}), 32'({1'b0, 8'hAA}));
        step();
        check("stall_next", 32'({tx_valid, tx_data, tx_ch}), 32'({1'b1, 8'h44, 4'h1}));
        step();
        check("stall_leds", 32'({tx_valid, leds}), 32'({1'b0, 8'h44}));
        step();
        check("stall_idle", 32'({tx_valid, drop_cnt}), 32'({1'b0, 8'h01}));

        // reset mid-transfer with ch1 still pending
        f0 = 1'b0; d0 = 8'h77; f1 = 1'b1; d1 = 8'h99; tx_ready = 1'b0;
        step();
        step();
        check("abort_grant", 32'({tx_valid, tx_data, tx_ch}), 32'({1'b1, 8'h77, 4'h0}));
        rst = 1'b1;
        step();
        check("abort_reset", 32'(obs), 32'(o(0, 8'h00, 4'h0, 0, 8'h00, 8'h00)));
        rst = 1'b0; tx_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("abort_no_send", 32'(tx_valid), 32'd0);
        end
`else
        // tagged mode: ch0 byte first so the ch1 8'h00 visibly updates leds
        f0 = 1'b0; d0 = 8'h5A; tx_ready = 1'b1;
        step();
        check("tag0_pend", 32'(tx_valid), 32'd0);
        step();
        check("tag0_tag", 32'({tx_valid, tx_data, tx_ch, sched_busy}), 32'({1'b1, 8'hF0, 4'h0, 1'b1}));
        step();
        check("tag0_data", 32'({tx_valid, tx_data, tx_ch, leds}), 32'({1'b1, 8'h5A, 4'h0, 8'h00}));
        step();
        check("tag0_done", 32'({tx_valid, leds}), 32'({1'b0, 8'h5A}));
        f1 = 1'b1; d1 = 8'h00;
        step();
        check("tag1_pend", 32'(tx_valid), 32'd0);
        step();
        check("tag1_tag", 32'({tx_valid, tx_data, tx_ch}), 32'({1'b1, 8'hF1, 4'h1}));
        step();
        check("tag1_data", 32'({tx_valid, tx_data, tx_ch, leds}), 32'({1'b1, 8'h00, 4'h1, 8'h5A}));
        step();
        check("tag1_done", 32'({tx_valid, leds, sched_busy}), 32'({1'b0, 8'h00, 1'b0}));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
